// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_ctrl_if
//  Brief   : ID-stage hazard controller signal bundle (pipeline side / control side)
//  Revision: 1.0
// ============================================================================
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      inst;
    logic             inst_valid;
    logic             w_f_wb;
    logic [4:0]       addr_in_f_wb;
    logic             br_resolve_f_ex;
    logic             br_taken_f_ex;
    logic             stall_2_if;
    logic             bubble_2_ex;
    logic             flush_2_if;
    logic             halted;
    logic [31:0]      pending;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output inst, inst_valid, w_f_wb, addr_in_f_wb, br_resolve_f_ex, br_taken_f_ex,
        input  stall_2_if, bubble_2_ex, flush_2_if, halted, pending, stall_cnt
    );

    modport slave (
        input  inst, inst_valid, w_f_wb, addr_in_f_wb, br_resolve_f_ex, br_taken_f_ex,
        output stall_2_if, bubble_2_ex, flush_2_if, halted, pending, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_ctrl
//  Brief   : Scoreboard RAW interlock, branch-wait/flush and HALT control
//  Revision: 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  wire logic      clk,
    input  wire logic      reset,
    hazard_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [5:0] c_op_ldw  = 6'b001100;
    localparam logic [5:0] c_op_stw  = 6'b001101;
    localparam logic [5:0] c_op_bz   = 6'b001110;
    localparam logic [5:0] c_op_beq  = 6'b001111;
    localparam logic [5:0] c_op_jr   = 6'b010000;
    localparam logic [5:0] c_op_halt = 6'b010001;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [31:0]      pending_q, pending_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [5:0] w_op;
    logic [4:0] w_rs, w_rt, w_rd, w_dest;
    logic       w_use_rs, w_use_rt, w_has_dest, w_is_branch, w_is_halt;
    logic       w_raw, w_issue, w_stall;

    assign w_op = bus.inst[31:26];
    assign w_rs = bus.inst[25:21];
    assign w_rt = bus.inst[20:16];
    assign w_rd = bus.inst[15:11];

    always_comb begin
        w_use_rs    = 1'b0;
        w_use_rt    = 1'b0;
        w_has_dest  = 1'b0;
        w_dest      = w_rd;
        w_is_branch = 1'b0;
        w_is_halt   = 1'b0;
        case (w_op)
            6'b000000, 6'b000010, 6'b000100, 6'b000110, 6'b001000, 6'b001010: begin
                w_use_rs   = 1'b1;
                w_use_rt   = 1'b1;
                w_has_dest = 1'b1;
            end
            6'b000001, 6'b000011, 6'b000101, 6'b000111, 6'b001001, 6'b001011, c_op_ldw: begin
                w_use_rs   = 1'b1;
                w_has_dest = 1'b1;
                w_dest     = w_rt;
            end
            c_op_stw: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            c_op_bz, c_op_jr: begin
                w_use_rs    = 1'b1;
                w_is_branch = 1'b1;
            end
            c_op_beq: begin
                w_use_rs    = 1'b1;
                w_use_rt    = 1'b1;
                w_is_branch = 1'b1;
            end
            c_op_halt: w_is_halt = 1'b1;
            default: ;
        endcase
    end

    // pending_q[0] is held at zero, so r0 sources never match
    assign w_raw   = bus.inst_valid & ((w_use_rs & pending_q[w_rs]) | (w_use_rt & pending_q[w_rt]));
    assign w_issue = (state_q == ST_RUN) & bus.inst_valid & ~w_raw;
    assign w_stall = ((state_q == ST_RUN) & w_raw) | (state_q == ST_BR_WAIT) | (state_q == ST_HALT);

    always_comb begin
        pending_d = pending_q;
        if (bus.w_f_wb) begin
            pending_d[bus.addr_in_f_wb] = 1'b0;
        end
        // a new issue to the same register outranks the WB retire
        if (w_issue && w_has_dest) begin
            pending_d[w_dest] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (w_issue && w_is_halt) begin
                    state_d = ST_HALT;
                end else if (w_issue && w_is_branch) begin
                    state_d = ST_BR_WAIT;
                end
            end
            ST_BR_WAIT: begin
                if (bus.br_resolve_f_ex) begin
                    state_d = bus.br_taken_f_ex ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_stall && (state_q != ST_HALT) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            pending_q   <= 32'd0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_2_if  = w_stall;
    assign bus.bubble_2_ex = w_stall | (state_q == ST_FLUSH);
    assign bus.flush_2_if  = (state_q == ST_FLUSH);
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.pending     = pending_q;
    assign bus.stall_cnt   = stall_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// Directed bench for hazard_ctrl: a register-array / mode-flag model predicts
// every output each cycle; literal checks pin the model at key points.
module tb_hazard_ctrl;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) bus();
    hazard_ctrl #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // model state
    bit pend_m [32];
    int cnt_m;
    bit m_wait, m_flush, m_halt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // dst/src = -1 when the field is unused by the opcode
    function automatic void decode(input logic [31:0] i, output int dst, output int s0, output int s1);
        int op;
        op  = int'(i[31:26]);
        dst = -1; s0 = -1; s1 = -1;
        if (op <= 10 && (op % 2) == 0) begin
            dst = int'(i[15:11]); s0 = int'(i[25:21]); s1 = int'(i[20:16]);
        end else if ((op <= 11 && (op % 2) == 1) || op == 12) begin
            dst = int'(i[20:16]); s0 = int'(i[25:21]);
        end else if (op == 13 || op == 15) begin
            s0 = int'(i[25:21]); s1 = int'(i[20:16]);
        end else if (op == 14 || op == 16) begin
            s0 = int'(i[25:21]);
        end
    endfunction

    function automatic bit m_raw();
        int d, a, b;
        decode(bus.inst, d, a, b);
        return bus.inst_valid && ((a > 0 && pend_m[a]) || (b > 0 && pend_m[b]));
    endfunction

    function automatic bit m_run();
        return !(m_wait || m_flush || m_halt);
    endfunction

    function automatic bit m_stall();
        return m_halt || m_wait || (m_run() && m_raw());
    endfunction

    function automatic logic [31:0] m_pend();
        logic [31:0] p;
        for (int k = 0; k < 32; k++) p[k] = pend_m[k];
        return p;
    endfunction

    always @(posedge clk) begin
        int d, a, b, op;
        bit iss;
        if (!reset) begin
            for (int k = 0; k < 32; k++) pend_m[k] = 1'b0;
            cnt_m = 0; m_wait = 0; m_flush = 0; m_halt = 0;
        end else begin
            decode(bus.inst, d, a, b);
            op  = int'(bus.inst[31:26]);
            iss = m_run() && bus.inst_valid && !m_raw();
            if (m_stall() && !m_halt) cnt_m = (cnt_m < CMAX) ? cnt_m + 1 : CMAX;
            if (bus.w_f_wb) pend_m[bus.addr_in_f_wb] = 1'b0;
            if (iss && d > 0) pend_m[d] = 1'b1;
            if (m_flush) begin
                m_flush = 0;
            end else if (m_wait) begin
                if (bus.br_resolve_f_ex) begin
                    m_wait  = 0;
                    m_flush = bus.br_taken_f_ex;
                end
            end else if (!m_halt && iss) begin
                if (op == 17) m_halt = 1;
                else if (op == 14 || op == 15 || op == 16) m_wait = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_2_if",  {31'd0, bus.stall_2_if},  {31'd0, m_stall()});
            chk("bubble_2_ex", {31'd0, bus.bubble_2_ex}, {31'd0, m_stall() || m_flush});
            chk("flush_2_if",  {31'd0, bus.flush_2_if},  {31'd0, m_flush});
            chk("halted",      {31'd0, bus.halted},      {31'd0, m_halt});
            chk("pending",     bus.pending,               m_pend());
            chk("stall_cnt",   {28'd0, bus.stall_cnt},    cnt_m);
        end
    end

    function automatic logic [31:0] rop(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] iop(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rs);
        return {op, rs, rt, 16'h0001};
    endfunction

    task automatic cyc(input logic [31:0] i, input logic v, input logic wb = 1'b0,
                       input logic [4:0] wa = 5'd0, input logic res = 1'b0, input logic tk = 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.inst = i; bus.inst_valid = v; bus.w_f_wb = wb; bus.addr_in_f_wb = wa;
        bus.br_resolve_f_ex = res; bus.br_taken_f_ex = tk;
        @(negedge clk);
    endtask

    // reset cycle with a competing issue, WB write and taken resolve
    task automatic rst_cyc();
        @(posedge clk); #1;
        reset = 1'b0;
        bus.inst = iop(6'h01, 5'd9, 5'd0); bus.inst_valid = 1'b1;
        bus.w_f_wb = 1'b1; bus.addr_in_f_wb = 5'd3;
        bus.br_resolve_f_ex = 1'b1; bus.br_taken_f_ex = 1'b1;
        @(negedge clk);
    endtask

    task automatic lit_all_zero(input string tag);
        chk({tag, ".stall"},   {31'd0, bus.stall_2_if},  32'd0);
        chk({tag, ".bubble"},  {31'd0, bus.bubble_2_ex}, 32'd0);
        chk({tag, ".flush"},   {31'd0, bus.flush_2_if},  32'd0);
        chk({tag, ".halted"},  {31'd0, bus.halted},      32'd0);
        chk({tag, ".pending"}, bus.pending,               32'd0);
        chk({tag, ".cnt"},     {28'd0, bus.stall_cnt},    32'd0);
    endtask

    localparam logic [31:0] NOP = 32'd0;

    initial begin
        logic [31:0] add4, beq, bz7, dep;
        reset = 1'b0;
        bus.inst = NOP; bus.inst_valid = 1'b0; bus.w_f_wb = 1'b0; bus.addr_in_f_wb = 5'd0;
        bus.br_resolve_f_ex = 1'b0; bus.br_taken_f_ex = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        lit_all_zero("reset");

        // RAW on r3 resolved by WB
        add4 = rop(6'h00, 5'd4, 5'd3, 5'd1);
        cyc(rop(6'h00, 5'd3, 5'd1, 5'd2), 1'b1);
        chk("raw.first_no_stall", {31'd0, bus.stall_2_if}, 32'd0);
        cyc(add4, 1'b1);
        chk("raw.stall", {31'd0, bus.stall_2_if}, 32'd1);
        chk("raw.bubble", {31'd0, bus.bubble_2_ex}, 32'd1);
        cyc(add4, 1'b1);
        cyc(add4, 1'b1, 1'b1, 5'd3);
        chk("raw.stall_wb_cycle", {31'd0, bus.stall_2_if}, 32'd1);
        cyc(add4, 1'b1);
        chk("raw.released", {31'd0, bus.stall_2_if}, 32'd0);
        chk("raw.cnt3", {28'd0, bus.stall_cnt}, 32'd3);
        cyc(NOP, 1'b0, 1'b1, 5'd4);
        chk("raw.pend4", bus.pending, 32'h10);

        // set beats simultaneous clear on r5
        cyc(iop(6'h01, 5'd5, 5'd0), 1'b1, 1'b1, 5'd5);
        cyc(NOP, 1'b0);
        chk("setclr.pend5", bus.pending, 32'h20);
        cyc(NOP, 1'b0, 1'b1, 5'd5);
        cyc(NOP, 1'b0);

        // r0 is never pending
        cyc(iop(6'h01, 5'd0, 5'd1), 1'b1);
        cyc(rop(6'h00, 5'd6, 5'd0, 5'd0), 1'b1);
        chk("r0.pending", bus.pending, 32'd0);
        chk("r0.no_stall", {31'd0, bus.stall_2_if}, 32'd0);
        cyc(NOP, 1'b0, 1'b1, 5'd6);
        cyc(NOP, 1'b0);

        // BEQ taken after 2 cycles
        beq = rop(6'h0F, 5'd0, 5'd1, 5'd2);
        cyc(beq, 1'b1);
        cyc(rop(6'h00, 5'd11, 5'd1, 5'd2), 1'b1);
        chk("br.wait1", {31'd0, bus.stall_2_if}, 32'd1);
        cyc(rop(6'h00, 5'd11, 5'd1, 5'd2), 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        cyc(rop(6'h00, 5'd11, 5'd1, 5'd2), 1'b1);
        chk("br.flush", {31'd0, bus.flush_2_if}, 32'd1);
        chk("br.flush_bubble", {31'd0, bus.bubble_2_ex}, 32'd1);
        chk("br.flush_nostall", {31'd0, bus.stall_2_if}, 32'd0);
        cyc(NOP, 1'b0);
        chk("br.flush_one_cycle", {31'd0, bus.flush_2_if}, 32'd0);
        chk("br.cnt5", {28'd0, bus.stall_cnt}, 32'd5);

        // BEQ not taken
        cyc(beq, 1'b1);
        cyc(NOP, 1'b0);
        cyc(NOP, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc(NOP, 1'b0);
        chk("br.nt_noflush", {31'd0, bus.flush_2_if}, 32'd0);
        chk("br.cnt7", {28'd0, bus.stall_cnt}, 32'd7);

        // resolve ignored in RUN
        cyc(NOP, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        cyc(NOP, 1'b0);
        chk("br.run_ignore", {31'd0, bus.flush_2_if}, 32'd0);

        // BZ with pending source stalls in RUN before it issues
        bz7 = iop(6'h0E, 5'd0, 5'd7);
        cyc(iop(6'h01, 5'd7, 5'd0), 1'b1);
        cyc(bz7, 1'b1);
        cyc(bz7, 1'b1, 1'b1, 5'd7);
        cyc(bz7, 1'b1);
        chk("bz.issue", {31'd0, bus.stall_2_if}, 32'd0);
        cyc(NOP, 1'b0);
        cyc(NOP, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc(NOP, 1'b0);
        chk("bz.cnt11", {28'd0, bus.stall_cnt}, 32'd11);

        // HALT; WB still retires; reset recovers
        cyc(iop(6'h01, 5'd8, 5'd0), 1'b1);
        cyc(32'h4400_0000, 1'b1);
        chk("halt.issue_nostall", {31'd0, bus.stall_2_if}, 32'd0);
        cyc(NOP, 1'b0);
        chk("halt.halted", {31'd0, bus.halted}, 32'd1);
        chk("halt.stall", {31'd0, bus.stall_2_if}, 32'd1);
        cyc(NOP, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1);
        cyc(iop(6'h01, 5'd12, 5'd0), 1'b1);
        chk("halt.wb_clears", bus.pending, 32'd0);
        chk("halt.still", {31'd0, bus.halted}, 32'd1);
        chk("halt.cnt_frozen", {28'd0, bus.stall_cnt}, 32'd11);
        rst_cyc();
        cyc(NOP, 1'b0);
        lit_all_zero("halt_reset");

        // reset during BR_WAIT
        cyc(beq, 1'b1);
        cyc(NOP, 1'b0);
        chk("brw.stall", {31'd0, bus.stall_2_if}, 32'd1);
        rst_cyc();
        cyc(NOP, 1'b0);
        lit_all_zero("brw_reset");

        // counter saturation
        dep = rop(6'h00, 5'd10, 5'd9, 5'd0);
        cyc(iop(6'h01, 5'd9, 5'd0), 1'b1);
        for (int k = 0; k < (1 << CW) + 5; k++) cyc(dep, 1'b1);
        chk("sat.cnt", {28'd0, bus.stall_cnt}, CMAX);
        cyc(dep, 1'b1, 1'b1, 5'd9);
        cyc(dep, 1'b1);
        chk("sat.hold", {28'd0, bus.stall_cnt}, CMAX);
        chk("sat.released", {31'd0, bus.stall_2_if}, 32'd0);
        cyc(NOP, 1'b0, 1'b1, 5'd10);
        cyc(NOP, 1'b0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall performance counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-low (reset==0 clears state at the next rising clk).
REQ-004 SHALL have port inst  input  32  instruction currently held in the ID stage.
REQ-005 SHALL have port inst_valid  input  1  inst is a real instruction; 0 means it is a bubble.
REQ-006 SHALL have port w_f_wb  input  1  WB stage writes the register file this cycle.
REQ-007 SHALL have port addr_in_f_wb  input  5  register written by WB.
REQ-008 SHALL have port br_resolve_f_ex  input  1  one-cycle pulse; EX has resolved the outstanding branch.
REQ-009 SHALL have port br_taken_f_ex  input  1  branch outcome; qualified by br_resolve_f_ex.
REQ-010 SHALL have port stall_2_if  output  1  hold PC and the IF/ID register.
REQ-011 SHALL have port bubble_2_ex  output  1  force ID/EX control outputs to NOP (all zero).
REQ-012 SHALL have port flush_2_if  output  1  discard the instruction in IF/ID.
REQ-013 SHALL have port halted  output  1  the core has stopped on HALT.
REQ-014 SHALL have port pending  output  32  scoreboard: bit n=1 means a write to register n is in flight.
REQ-015 SHALL have port stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-016 SHALL decode opcode=inst[31:26]: R-ops 000000,000010,000100,000110,001000,001010 (dest inst[15:11], sources rs=inst[25:21] and rt=inst[20:16]); I-ops 000001,000011,000101,000111,001001,001011 and LDW 001100 (dest inst[20:16], source rs); STW 001101 (sources rs and rt, no dest); BZ 001110 and JR 010000 (source rs); BEQ 001111 (sources rs and rt); HALT 010001 (no operands); any other opcode is a NOP with no operands.
REQ-017 SHALL treat register 0 as never pending: pending[0] is constantly 0 and a source of 0 never causes a hazard.
REQ-018 SHALL define raw as inst_valid AND any used source register having its pending bit set in the registered scoreboard.
REQ-019 SHALL clear pending[addr_in_f_wb] on a WB write only at the end of that cycle, so a source matching the WB address still counts as a hazard in the same cycle.
REQ-020 SHALL define issue as state==RUN AND inst_valid AND NOT raw.
REQ-021 SHALL, on issue of an instruction with a destination register, set pending[dest] at the next edge.
REQ-022 SHALL let a set win over a clear when both target the same register in the same cycle.
REQ-023 SHALL implement a registered FSM with states RUN, BR_WAIT, FLUSH and HALT.
REQ-024 SHALL, in RUN: go to HALT when HALT issues; go to BR_WAIT when BZ, BEQ or JR issues; otherwise stay in RUN.
REQ-025 SHALL ignore br_resolve_f_ex in RUN, FLUSH and HALT.
REQ-026 SHALL, in BR_WAIT: go to FLUSH on br_resolve_f_ex with br_taken_f_ex=1; go to RUN on br_resolve_f_ex with br_taken_f_ex=0; otherwise stay.
REQ-027 SHALL leave FLUSH for RUN after exactly one cycle.
REQ-028 SHALL leave HALT only through reset.
REQ-029 SHALL drive stall_2_if and bubble_2_ex combinationally as (state==RUN AND raw) OR state==BR_WAIT OR state==HALT; bubble_2_ex is also 1 in FLUSH.
REQ-030 SHALL drive flush_2_if=1 only in FLUSH.
REQ-031 SHALL drive halted=1 only in HALT.
REQ-032 SHALL give a HALT instruction no RAW check, since it has no sources.
REQ-033 SHALL stall a branch whose sources are pending in RUN, and enter BR_WAIT only on the cycle it issues.
REQ-034 SHALL increment stall_cnt by 1 on every cycle with stall_2_if=1 and state!=HALT, saturating at all ones with no wrap.
REQ-035 SHALL keep clearing scoreboard bits on WB writes in every state, including HALT.

Reset
REQ-036 SHALL, on reset==0 at a rising edge, set state=RUN, pending=0 and stall_cnt=0, overriding any simultaneous issue, WB write or branch resolve.
REQ-037 SHALL, with state=RUN, pending=0 and stall_cnt=0, drive every output to 0, including after a reset applied mid-BR_WAIT or mid-HALT.

Verification
REQ-038 SHALL verify: issue add r3=r1+r2, next cycle add r4=r3+r1 -> stall_2_if and bubble_2_ex high until the cycle after WB writes r3; stall_cnt matches the stalled cycle count.
REQ-039 SHALL verify: WB writes r5 in the same cycle that r5 is issued as a destination -> pending[5] stays 1.
REQ-040 SHALL verify: BEQ issues, br_resolve_f_ex arrives 2 cycles later with taken=1 -> stall for 2 cycles, flush_2_if high exactly 1 cycle, then RUN; with taken=0 -> no flush.
REQ-041 SHALL verify: addi r0 issues, then a read of r0 -> pending[0]=0 and no stall.
REQ-042 SHALL verify: HALT issues -> halted=1 and stall_2_if=1 permanently; pulse reset=0 for 1 cycle -> all outputs 0.
REQ-043 SHALL verify: force 2^CNT_W+5 stall cycles -> stall_cnt holds at all ones.
